// File: rtl/matrix_row_scanner.sv
// ============================================================================
// matrix_row_scanner: LED matrix row-scan driver (blank gap, dwell, polarity).
// Optional dimming via macro MATRIX_SCAN_BRIGHT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_row_scanner #(
  parameter int ROW_NUM      = 8,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 0,
  parameter int IDX_W        = $clog2(ROW_NUM),
  parameter int CNT_W        = $clog2(((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               scan_en_i,
  output logic [ROW_NUM-1:0] row_sel_o,
  output logic [IDX_W-1:0]   row_idx_o,
  output logic               row_start_o,
  output logic               frame_start_o,
  output logic               blank_o
`ifdef MATRIX_SCAN_BRIGHT_EN
  ,
  input  logic [CNT_W-1:0]   bright_i
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [ROW_NUM-1:0] SEL_OFF    = (ACTIVE_LOW != 0) ? {ROW_NUM{1'b1}} : {ROW_NUM{1'b0}};
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(ROW_NUM - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_d;
  logic [ROW_NUM-1:0] sel_d;
  logic               row_start_d;
  logic               frame_start_d;
  logic               blank_d;
  logic               lit;
`ifdef MATRIX_SCAN_BRIGHT_EN
  logic [CNT_W-1:0]   bright_q, bright_d;
`endif

  // Outputs are computed from the next state so they can be registered
  // alongside the state itself.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    idx_d         = row_idx_o;
    row_start_d   = 1'b0;
    frame_start_d = 1'b0;
    blank_d       = 1'b1;
    sel_d         = SEL_OFF;
    lit           = 1'b0;
`ifdef MATRIX_SCAN_BRIGHT_EN
    bright_d      = bright_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_en_i) begin
          state_d = BLANK;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      BLANK: begin
        if (!scan_en_i) begin
          state_d = IDLE;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == BLANK_LAST) begin
          state_d       = DRIVE;
          timer_d       = '0;
          row_start_d   = 1'b1;
          frame_start_d = (row_idx_o == '0);
          blank_d       = 1'b0;
`ifdef MATRIX_SCAN_BRIGHT_EN
          bright_d      = bright_i;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRIVE: begin
        if (!scan_en_i) begin
          state_d = IDLE;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == DWELL_LAST) begin
          state_d = BLANK;
          timer_d = '0;
          idx_d   = (row_idx_o == IDX_LAST) ? '0 : row_idx_o + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          blank_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase

`ifdef MATRIX_SCAN_BRIGHT_EN
    lit = (state_d == DRIVE) && (timer_d < bright_d);
`else
    lit = (state_d == DRIVE);
`endif

    for (int r = 0; r < ROW_NUM; r++) begin
      sel_d[r] = SEL_OFF[r] ^ (lit && (idx_d == IDX_W'(r)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      row_idx_o     <= '0;
      row_sel_o     <= SEL_OFF;
      row_start_o   <= 1'b0;
      frame_start_o <= 1'b0;
      blank_o       <= 1'b1;
`ifdef MATRIX_SCAN_BRIGHT_EN
      bright_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      row_idx_o     <= idx_d;
      row_sel_o     <= sel_d;
      row_start_o   <= row_start_d;
      frame_start_o <= frame_start_d;
      blank_o       <= blank_d;
`ifdef MATRIX_SCAN_BRIGHT_EN
      bright_q      <= bright_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_row_scanner.sv
// ============================================================================
// tb_matrix_row_scanner: directed bench with a timeline-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_row_scanner;

  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + D;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] bright;
  logic [7:0] sel_a;
  logic [2:0] idx_a;
  logic       rs_a, fs_a, blank_a;
  logic [5:0] sel_b;
  logic [2:0] idx_b;
  logic       rs_b, fs_b, blank_b;

  int total = 0;
  int bad   = 0;
  int rc    = 0;
  int k     = -1;
  int bq    = 1000;
  bit live  = 1'b0;

  always #5 clk = ~clk;

  matrix_row_scanner #(
    .ROW_NUM(8), .DWELL_CYCLES(D), .BLANK_CYCLES(B), .ACTIVE_LOW(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .scan_en_i(en),
    .row_sel_o(sel_a), .row_idx_o(idx_a), .row_start_o(rs_a),
    .frame_start_o(fs_a), .blank_o(blank_a)
`ifdef MATRIX_SCAN_BRIGHT_EN
    , .bright_i(bright)
`endif
  );

  matrix_row_scanner #(
    .ROW_NUM(6), .DWELL_CYCLES(D), .BLANK_CYCLES(B), .ACTIVE_LOW(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .scan_en_i(en),
    .row_sel_o(sel_b), .row_idx_o(idx_b), .row_start_o(rs_b),
    .frame_start_o(fs_b), .blank_o(blank_b)
`ifdef MATRIX_SCAN_BRIGHT_EN
    , .bright_i(bright)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t rc=%0d: actual=%h required=%h", nm, $time, rc, act, exp);
    end
  endtask

  // Model state: k counts cycles since the scan was enabled (-1 while idle).
  always @(posedge clk) begin
    if (rst || !en)  k = -1;
    else if (k < 0)  k = 0;
    else             k = k + 1;
`ifdef MATRIX_SCAN_BRIGHT_EN
    if (k >= 0 && (k % P) == B) bq = int'(bright);
`endif
    live = 1'b1;
  end

  task automatic cmp_dut(input string nm, input int rows, input bit al,
                         input logic [31:0] sel, input logic [31:0] idx,
                         input logic rs, input logic fs, input logic blank);
    int p, row;
    logic [31:0] esel;
    bit eblank, ers, efs, elit;
    if (k < 0) begin
      row = 0; eblank = 1'b1; ers = 1'b0; efs = 1'b0; elit = 1'b0;
    end else begin
      p      = k % P;
      row    = (k / P) % rows;
      eblank = (p < B);
      ers    = (p == B);
      efs    = ers && (row == 0);
      elit   = (p >= B) && ((p - B) < bq);
    end
    esel = elit ? (32'd1 << row) : 32'd0;
    if (al) esel = ~esel & ((32'd1 << rows) - 32'd1);
    chk({nm, "_sel"},   sel, esel);
    chk({nm, "_idx"},   idx, 32'(row));
    chk({nm, "_start"}, {31'd0, rs}, {31'd0, ers});
    chk({nm, "_frame"}, {31'd0, fs}, {31'd0, efs});
    chk({nm, "_blank"}, {31'd0, blank}, {31'd0, eblank});
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp_dut("a", 8, 1'b0, {24'd0, sel_a}, {29'd0, idx_a}, rs_a, fs_a, blank_a);
      cmp_dut("b", 6, 1'b1, {26'd0, sel_b}, {29'd0, idx_b}, rs_b, fs_b, blank_b);
      chk("b_idx_range", {31'd0, (idx_b > 3'd5)}, 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
    rc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bright = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst_sel_a",   {24'd0, sel_a}, 32'h00);
    chk("rst_idx_a",   {29'd0, idx_a}, 32'd0);
    chk("rst_blank_a", {31'd0, blank_a}, 32'd1);
    chk("rst_start_a", {31'd0, rs_a}, 32'd0);
    chk("rst_sel_b",   {26'd0, sel_b}, 32'h3F);

    // Frame run: scan enabled from edge 0.
    rst = 1'b0; rc = 0;
    while (rc < 70) begin
      step();
      case (rc)
        1, 2: chk("blank_sel_a", {24'd0, sel_a}, 32'h00);
        3: begin
          chk("r0_sel_a",   {24'd0, sel_a}, 32'h01);
          chk("r0_start_a", {31'd0, rs_a}, 32'd1);
          chk("r0_frame_a", {31'd0, fs_a}, 32'd1);
          chk("r0_sel_b",   {26'd0, sel_b}, 32'h3E);
        end
        6: chk("r0_end_sel_a", {24'd0, sel_a}, 32'h01);
        7: chk("gap_sel_a", {24'd0, sel_a}, 32'h00);
`ifdef MATRIX_SCAN_BRIGHT_EN
        8:  bright = 3'd1;
        9:  chk("dim1_sel_a", {24'd0, sel_a}, 32'h02);
        10: chk("dim1_off_a", {24'd0, sel_a}, 32'h00);
        14: bright = 3'd0;
        15: begin
          chk("dim0_sel_a",   {24'd0, sel_a}, 32'h00);
          chk("dim0_start_a", {31'd0, rs_a}, 32'd1);
        end
        20: bright = 3'd7;
`else
        9:  begin
          chk("r1_sel_a",   {24'd0, sel_a}, 32'h02);
          chk("r1_frame_a", {31'd0, fs_a}, 32'd0);
        end
        12: chk("r1_end_sel_a", {24'd0, sel_a}, 32'h02);
        15: chk("r2_sel_a", {24'd0, sel_a}, 32'h04);
`endif
        24: chk("r3_sel_a", {24'd0, sel_a}, 32'h08);
        33: chk("r5_sel_b", {26'd0, sel_b}, 32'h1F);
        37: begin
          chk("wrap_blank_b", {26'd0, sel_b}, 32'h3F);
          chk("wrap_idx_b",   {29'd0, idx_b}, 32'd0);
        end
        39: chk("wrap_sel_b", {26'd0, sel_b}, 32'h3E);
        45: chk("r7_sel_a", {24'd0, sel_a}, 32'h80);
        49: chk("r7_gap_a", {24'd0, sel_a}, 32'h00);
        51: begin
          chk("f2_sel_a",   {24'd0, sel_a}, 32'h01);
          chk("f2_frame_a", {31'd0, fs_a}, 32'd1);
        end
        57: chk("f2_r1_start_a", {31'd0, rs_a}, 32'd1);
        70: begin
          chk("r3_idx_a",    {29'd0, idx_a}, 32'd3);
          chk("r3_f2_sel_a", {24'd0, sel_a}, 32'h08);
          en = 1'b0;
        end
        default: ;
      endcase
    end

    // Enable dropped during row 3 drive.
    step();
    chk("drop_sel_a",   {24'd0, sel_a}, 32'h00);
    chk("drop_idx_a",   {29'd0, idx_a}, 32'd0);
    chk("drop_blank_a", {31'd0, blank_a}, 32'd1);
    step();
    en = 1'b1; rc = 0;
    while (rc < 34) begin
      step();
      if (rc == 2) chk("re_blank_a", {24'd0, sel_a}, 32'h00);
      if (rc == 3) begin
        chk("re_sel_a",   {24'd0, sel_a}, 32'h01);
        chk("re_frame_a", {31'd0, fs_a}, 32'd1);
      end
    end
    chk("r5_idx_a", {29'd0, idx_a}, 32'd5);
    chk("r5_sel_a", {24'd0, sel_a}, 32'h20);
    rst = 1'b1;

    // Reset asserted during row 5 drive.
    step();
    chk("mid_rst_sel_a",   {24'd0, sel_a}, 32'h00);
    chk("mid_rst_idx_a",   {29'd0, idx_a}, 32'd0);
    chk("mid_rst_blank_a", {31'd0, blank_a}, 32'd1);
    chk("mid_rst_start_a", {31'd0, rs_a}, 32'd0);
    chk("mid_rst_sel_b",   {26'd0, sel_b}, 32'h3F);
    rst = 1'b0; rc = 0;
    while (rc < 12) begin
      step();
      if (rc == 3) begin
        chk("post_rst_sel_a",   {24'd0, sel_a}, 32'h01);
        chk("post_rst_frame_a", {31'd0, fs_a}, 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
